// File: rtl/decode_stage_pipe_pkg.sv
// Shared definitions for the decode stage: default widths, MIPS opcode and
// funct constants, the link-register index, and the opcode decoder that
// turns opcode/funct into control bits plus a destination selector.
package decode_stage_pipe_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_AWIDTH = 5;
  localparam int DEF_IWIDTH = 32;

  // jal writes its return address here
  localparam int REG_LINK = 31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2,
    DST_LINK = 2'd3
  } dst_sel_e;

  typedef struct packed {
    logic reg_wr;
    logic memtoreg;
    logic memwrite;
    logic alu_src;
    logic branch;
    logic jal;
    logic jr;
  } ctrl_t;

  typedef struct packed {
    ctrl_t    ctrl;
    dst_sel_e dst_sel;
    logic     rt_used;
  } dec_t;

  // Unknown opcodes and j fall through as all-zero controls (NOP)
  function automatic dec_t decode_op(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.dst_sel = DST_RD;
        d.rt_used = 1'b1;
        if (fn == FN_JR) d.ctrl.jr = 1'b1;
        else             d.ctrl.reg_wr = 1'b1;
      end
      OP_LW: begin
        d.dst_sel       = DST_RT;
        d.ctrl.alu_src  = 1'b1;
        d.ctrl.memtoreg = 1'b1;
        d.ctrl.reg_wr   = 1'b1;
      end
      OP_SW: begin
        d.rt_used       = 1'b1;
        d.ctrl.alu_src  = 1'b1;
        d.ctrl.memwrite = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.rt_used     = 1'b1;
        d.ctrl.branch = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        d.dst_sel      = DST_RT;
        d.ctrl.alu_src = 1'b1;
        d.ctrl.reg_wr  = 1'b1;
      end
      OP_JAL: begin
        d.dst_sel     = DST_LINK;
        d.ctrl.jal    = 1'b1;
        d.ctrl.reg_wr = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_regfile_bypass.sv
// Register file with two combinational read ports and one write port.
// Register 0 is hard-wired to zero. With BYPASS_EN=1 a write landing this
// cycle is returned on a matching read (write-first); address 0 never bypasses.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears all regs)
//   we, waddr, wdata      write port (takes effect at the clock edge)
//   raddr_a/rdata_a       read port A
//   raddr_b/rdata_b       read port B
module regfile_bypass
  import decode_stage_pipe_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr_a,
  input  logic [AWIDTH-1:0] raddr_b,
  output logic [DWIDTH-1:0] rdata_a,
  output logic [DWIDTH-1:0] rdata_b
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) begin
      if (BYPASS_EN && we && (waddr == raddr_a)) rdata_a = wdata;
      else                                       rdata_a = mem_q[raddr_a];
    end
    rdata_b = '0;
    if (raddr_b != '0) begin
      if (BYPASS_EN && we && (waddr == raddr_b)) rdata_b = wdata;
      else                                       rdata_b = mem_q[raddr_b];
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: accepts an instruction over a valid/ready handshake,
// decodes it, reads operands (with writeback bypass) and registers the
// ID/EX bundle. Stalls one cycle on load-use, honours execute back-pressure
// and flush.
// Ports:
//   dp_clk, dp_rst                  clock, synchronous active-low reset
//   dp_i_valid/dp_o_ready           IF/ID handshake; dp_i_instr, dp_i_pc payload
//   dp_i_ex_ready, dp_i_flush       execute back-pressure and squash
//   dp_i_reg_wr/addr_rd/data_rd     writeback port into the register file
//   dp_o_*                          registered ID/EX bundle
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int IWIDTH    = DEF_IWIDTH,
  parameter bit BYPASS_EN = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              dp_clk,
  input  logic              dp_rst,
  input  logic              dp_i_valid,
  output logic              dp_o_ready,
  input  logic [IWIDTH-1:0] dp_i_instr,
  input  logic [DWIDTH-1:0] dp_i_pc,
  input  logic              dp_i_ex_ready,
  input  logic              dp_i_flush,
  input  logic              dp_i_reg_wr,
  input  logic [AWIDTH-1:0] dp_i_addr_rd,
  input  logic [DWIDTH-1:0] dp_i_data_rd,
  output logic              dp_o_valid,
  output logic [5:0]        dp_o_opcode,
  output logic [5:0]        dp_o_funct,
  output logic [AWIDTH-1:0] dp_o_addr_rs,
  output logic [AWIDTH-1:0] dp_o_addr_rt,
  output logic [AWIDTH-1:0] dp_o_addr_dst,
  output logic [DWIDTH-1:0] dp_o_data_rs,
  output logic [DWIDTH-1:0] dp_o_data_rt,
  output logic [DWIDTH-1:0] dp_o_imm,
  output logic [25:0]       dp_o_jal_addr,
  output logic [DWIDTH-1:0] dp_o_link,
  output logic              dp_o_reg_wr,
  output logic              dp_o_memtoreg,
  output logic              dp_o_memwrite,
  output logic              dp_o_alu_src,
  output logic              dp_o_branch,
  output logic              dp_o_jal,
  output logic              dp_o_jr
);

  // Instruction fields
  logic [5:0]        opcode, funct;
  logic [AWIDTH-1:0] rs, rt, rd, dst;
  logic [DWIDTH-1:0] imm, link, rdata_rs, rdata_rt;
  dec_t              dec;
  logic              hazard;

  assign opcode = dp_i_instr[31:26];
  assign funct  = dp_i_instr[5:0];
  assign rs     = AWIDTH'(dp_i_instr[25:21]);
  assign rt     = AWIDTH'(dp_i_instr[20:16]);
  assign rd     = AWIDTH'(dp_i_instr[15:11]);
  assign imm    = {{(DWIDTH-16){dp_i_instr[15]}}, dp_i_instr[15:0]};
  assign link   = dp_i_pc + DWIDTH'(8);
  assign dec    = decode_op(opcode, funct);

  always_comb begin
    case (dec.dst_sel)
      DST_RD:   dst = rd;
      DST_RT:   dst = rt;
      DST_LINK: dst = AWIDTH'(REG_LINK);
      default:  dst = '0;
    endcase
  end

  regfile_bypass #(
    .DWIDTH    (DWIDTH),
    .AWIDTH    (AWIDTH),
    .BYPASS_EN (BYPASS_EN)
  ) u_rf (
    .clk     (dp_clk),
    .rst_n   (dp_rst),
    .we      (dp_i_reg_wr),
    .waddr   (dp_i_addr_rd),
    .wdata   (dp_i_data_rd),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rdata_rs),
    .rdata_b (rdata_rt)
  );

  // ID/EX register
  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [5:0]        opcode_q, opcode_d, funct_q, funct_d;
  logic [AWIDTH-1:0] rs_q, rs_d, rt_q, rt_d, dst_q, dst_d;
  logic [DWIDTH-1:0] data_rs_q, data_rs_d, data_rt_q, data_rt_d;
  logic [DWIDTH-1:0] imm_q, imm_d, link_q, link_d;
  logic [25:0]       jal_addr_q, jal_addr_d;

  // Load in ID/EX whose destination feeds this instruction: the value is not
  // available until after MEM, so hold the input for one cycle.
  assign hazard = HAZARD_EN && dp_i_valid && valid_q && ctrl_q.memtoreg &&
                  (dst_q != '0) &&
                  ((dst_q == rs) || (dec.rt_used && (dst_q == rt)));

  assign dp_o_ready = dp_i_ex_ready && !hazard && !dp_i_flush;

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    opcode_d   = opcode_q;
    funct_d    = funct_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    dst_d      = dst_q;
    data_rs_d  = data_rs_q;
    data_rt_d  = data_rt_q;
    imm_d      = imm_q;
    link_d     = link_q;
    jal_addr_d = jal_addr_q;
    if (dp_i_flush) begin
      valid_d = 1'b0;
    end else if (!dp_i_ex_ready) begin
      // hold; writebacks during the hold are forwarded by execute
    end else if (hazard) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (dp_i_valid) begin
      valid_d    = 1'b1;
      ctrl_d     = dec.ctrl;
      opcode_d   = opcode;
      funct_d    = funct;
      rs_d       = rs;
      rt_d       = rt;
      dst_d      = dst;
      data_rs_d  = rdata_rs;
      data_rt_d  = rdata_rt;
      imm_d      = imm;
      link_d     = link;
      jal_addr_d = dp_i_instr[25:0];
    end else begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge dp_clk) begin
    if (!dp_rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      opcode_q   <= '0;
      funct_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dst_q      <= '0;
      data_rs_q  <= '0;
      data_rt_q  <= '0;
      imm_q      <= '0;
      link_q     <= '0;
      jal_addr_q <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      opcode_q   <= opcode_d;
      funct_q    <= funct_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dst_q      <= dst_d;
      data_rs_q  <= data_rs_d;
      data_rt_q  <= data_rt_d;
      imm_q      <= imm_d;
      link_q     <= link_d;
      jal_addr_q <= jal_addr_d;
    end
  end

  assign dp_o_valid    = valid_q;
  assign dp_o_opcode   = opcode_q;
  assign dp_o_funct    = funct_q;
  assign dp_o_addr_rs  = rs_q;
  assign dp_o_addr_rt  = rt_q;
  assign dp_o_addr_dst = dst_q;
  assign dp_o_data_rs  = data_rs_q;
  assign dp_o_data_rt  = data_rt_q;
  assign dp_o_imm      = imm_q;
  assign dp_o_jal_addr = jal_addr_q;
  assign dp_o_link     = link_q;
  assign dp_o_reg_wr   = ctrl_q.reg_wr;
  assign dp_o_memtoreg = ctrl_q.memtoreg;
  assign dp_o_memwrite = ctrl_q.memwrite;
  assign dp_o_alu_src  = ctrl_q.alu_src;
  assign dp_o_branch   = ctrl_q.branch;
  assign dp_o_jal      = ctrl_q.jal;
  assign dp_o_jr       = ctrl_q.jr;

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n, i_valid, ex_ready, flush, wb_we;
  logic [31:0] instr, pc, wb_data;
  logic [4:0]  wb_addr;

  // bypass-enabled DUT
  logic        o_ready, o_valid, o_reg_wr, o_memtoreg, o_memwrite, o_alu_src, o_branch, o_jal, o_jr;
  logic [5:0]  o_opcode, o_funct;
  logic [4:0]  o_rs, o_rt, o_dst;
  logic [31:0] o_data_rs, o_data_rt, o_imm, o_link;
  logic [25:0] o_jal_addr;

  // bypass-disabled DUT, same stimulus
  logic        b_ready, b_valid, b_reg_wr, b_memtoreg, b_memwrite, b_alu_src, b_branch, b_jal, b_jr;
  logic [5:0]  b_opcode, b_funct;
  logic [4:0]  b_rs, b_rt, b_dst;
  logic [31:0] b_data_rs, b_data_rt, b_imm, b_link;
  logic [25:0] b_jal_addr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.BYPASS_EN(1'b1)) u_dut (
    .dp_clk(clk), .dp_rst(rst_n), .dp_i_valid(i_valid), .dp_o_ready(o_ready),
    .dp_i_instr(instr), .dp_i_pc(pc), .dp_i_ex_ready(ex_ready), .dp_i_flush(flush),
    .dp_i_reg_wr(wb_we), .dp_i_addr_rd(wb_addr), .dp_i_data_rd(wb_data),
    .dp_o_valid(o_valid), .dp_o_opcode(o_opcode), .dp_o_funct(o_funct),
    .dp_o_addr_rs(o_rs), .dp_o_addr_rt(o_rt), .dp_o_addr_dst(o_dst),
    .dp_o_data_rs(o_data_rs), .dp_o_data_rt(o_data_rt), .dp_o_imm(o_imm),
    .dp_o_jal_addr(o_jal_addr), .dp_o_link(o_link), .dp_o_reg_wr(o_reg_wr),
    .dp_o_memtoreg(o_memtoreg), .dp_o_memwrite(o_memwrite), .dp_o_alu_src(o_alu_src),
    .dp_o_branch(o_branch), .dp_o_jal(o_jal), .dp_o_jr(o_jr)
  );

  decode_stage_pipe #(.BYPASS_EN(1'b0)) u_nobyp (
    .dp_clk(clk), .dp_rst(rst_n), .dp_i_valid(i_valid), .dp_o_ready(b_ready),
    .dp_i_instr(instr), .dp_i_pc(pc), .dp_i_ex_ready(ex_ready), .dp_i_flush(flush),
    .dp_i_reg_wr(wb_we), .dp_i_addr_rd(wb_addr), .dp_i_data_rd(wb_data),
    .dp_o_valid(b_valid), .dp_o_opcode(b_opcode), .dp_o_funct(b_funct),
    .dp_o_addr_rs(b_rs), .dp_o_addr_rt(b_rt), .dp_o_addr_dst(b_dst),
    .dp_o_data_rs(b_data_rs), .dp_o_data_rt(b_data_rt), .dp_o_imm(b_imm),
    .dp_o_jal_addr(b_jal_addr), .dp_o_link(b_link), .dp_o_reg_wr(b_reg_wr),
    .dp_o_memtoreg(b_memtoreg), .dp_o_memwrite(b_memwrite), .dp_o_alu_src(b_alu_src),
    .dp_o_branch(b_branch), .dp_o_jal(b_jal), .dp_o_jr(b_jr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 0; flush = 0; ex_ready = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
    instr = 0; pc = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    tick(); tick();
    total++;
    if ({o_valid, o_reg_wr, o_dst, o_data_rs, o_imm} !== 40'd0) begin
      $display("FAIL reset_outputs: got valid=%0b reg_wr=%0b dst=%0d rs=%h imm=%h, want all 0",
               o_valid, o_reg_wr, o_dst, o_data_rs, o_imm);
    end else passed++;
    rst_n = 1;
  endtask

  task automatic test_addi();
    instr = 32'h20010005; pc = 32'h40; i_valid = 1;
    #1;
    total++;
    if (o_ready !== 1'b1) $display("FAIL addi_ready: got %0b want 1", o_ready);
    else passed++;
    tick();
    total++;
    if ({o_valid, o_dst, o_imm, o_alu_src, o_reg_wr, o_memtoreg, o_data_rs, o_opcode} !==
        {1'b1, 5'd1, 32'd5, 1'b1, 1'b1, 1'b0, 32'd0, 6'h08}) begin
      $display("FAIL addi_bundle: got v=%0b dst=%0d imm=%h alu=%0b wr=%0b m2r=%0b rs=%h op=%h, want v=1 dst=1 imm=5 alu=1 wr=1 m2r=0 rs=0 op=08",
               o_valid, o_dst, o_imm, o_alu_src, o_reg_wr, o_memtoreg, o_data_rs, o_opcode);
    end else passed++;
    // addi $1,$0,-1 : sign extension
    instr = 32'h2001FFFF;
    tick();
    total++;
    if (o_imm !== 32'hFFFFFFFF) $display("FAIL addi_sext: got %h want ffffffff", o_imm);
    else passed++;
    i_valid = 0;
    tick();
    total++;
    if ({o_valid, o_reg_wr, o_alu_src} !== 3'b000)
      $display("FAIL idle_bubble: got v=%0b wr=%0b alu=%0b want 000", o_valid, o_reg_wr, o_alu_src);
    else passed++;
  endtask

  task automatic test_bypass();
    // add $4,$3,$3 while WB writes $3
    instr = 32'h00632020; i_valid = 1;
    wb_we = 1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 0;
    total++;
    if ({o_valid, o_data_rs, o_data_rt, o_dst, o_reg_wr} !== {1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 5'd4, 1'b1})
      $display("FAIL bypass_on: got v=%0b rs=%h rt=%h dst=%0d wr=%0b want 1 deadbeef deadbeef 4 1",
               o_valid, o_data_rs, o_data_rt, o_dst, o_reg_wr);
    else passed++;
    total++;
    if ({b_data_rs, b_data_rt} !== 64'd0)
      $display("FAIL bypass_off: got rs=%h rt=%h want 0 0", b_data_rs, b_data_rt);
    else passed++;
    // the write itself landed in both register files
    tick();
    total++;
    if ({b_data_rs, b_data_rt} !== {32'hDEADBEEF, 32'hDEADBEEF})
      $display("FAIL write_landed: got rs=%h rt=%h want deadbeef deadbeef", b_data_rs, b_data_rt);
    else passed++;
    i_valid = 0;
    tick();
  endtask

  task automatic test_load_use();
    // lw $2,0($1)
    instr = 32'h8C220000; i_valid = 1;
    tick();
    total++;
    if ({o_valid, o_memtoreg, o_dst, o_alu_src} !== {1'b1, 1'b1, 5'd2, 1'b1})
      $display("FAIL lw_bundle: got v=%0b m2r=%0b dst=%0d alu=%0b want 1 1 2 1",
               o_valid, o_memtoreg, o_dst, o_alu_src);
    else passed++;
    // add $5,$2,$1 depends on the load
    instr = 32'h00412820;
    #1;
    total++;
    if (o_ready !== 1'b0) $display("FAIL load_use_ready: got %0b want 0", o_ready);
    else passed++;
    tick();
    total++;
    if ({o_valid, o_memtoreg, o_reg_wr, o_ready} !== 4'b0001)
      $display("FAIL load_use_bubble: got v=%0b m2r=%0b wr=%0b rdy=%0b want 0 0 0 1",
               o_valid, o_memtoreg, o_reg_wr, o_ready);
    else passed++;
    tick();
    total++;
    if ({o_valid, o_dst, o_rs, o_rt} !== {1'b1, 5'd5, 5'd2, 5'd1})
      $display("FAIL load_use_issue: got v=%0b dst=%0d rs=%0d rt=%0d want 1 5 2 1",
               o_valid, o_dst, o_rs, o_rt);
    else passed++;
    // lw again, then independent add $5,$6,$1
    instr = 32'h8C220000;
    tick();
    instr = 32'h00C12820;
    #1;
    total++;
    if (o_ready !== 1'b1) $display("FAIL no_hazard_ready: got %0b want 1", o_ready);
    else passed++;
    tick();
    total++;
    if ({o_valid, o_dst, o_rs, o_memtoreg} !== {1'b1, 5'd5, 5'd6, 1'b0})
      $display("FAIL no_hazard_issue: got v=%0b dst=%0d rs=%0d m2r=%0b want 1 5 6 0",
               o_valid, o_dst, o_rs, o_memtoreg);
    else passed++;
    i_valid = 0;
    tick();
  endtask

  task automatic test_zero_and_jal();
    // WB targets $0 while reading rs=$0 (add $7,$0,$0)
    instr = 32'h00003820; i_valid = 1;
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    wb_we = 0;
    total++;
    if ({o_data_rs, o_data_rt} !== 64'd0)
      $display("FAIL zero_no_bypass: got rs=%h rt=%h want 0 0", o_data_rs, o_data_rt);
    else passed++;
    tick();
    total++;
    if ({o_valid, o_data_rs} !== {1'b1, 32'd0})
      $display("FAIL zero_read: got v=%0b rs=%h want 1 0", o_valid, o_data_rs);
    else passed++;
    // jal 0x40 at pc 0x100
    instr = 32'h0C000040; pc = 32'h100;
    tick();
    total++;
    if ({o_valid, o_dst, o_link, o_jal_addr, o_jal, o_reg_wr} !==
        {1'b1, 5'd31, 32'h108, 26'h40, 1'b1, 1'b1})
      $display("FAIL jal_bundle: got v=%0b dst=%0d link=%h tgt=%h jal=%0b wr=%0b want 1 31 108 40 1 1",
               o_valid, o_dst, o_link, o_jal_addr, o_jal, o_reg_wr);
    else passed++;
    // sw $9,4($1): no write, uses rt
    instr = 32'hAC290004;
    tick();
    total++;
    if ({o_memwrite, o_reg_wr, o_dst, o_alu_src} !== {1'b1, 1'b0, 5'd0, 1'b1})
      $display("FAIL sw_bundle: got mw=%0b wr=%0b dst=%0d alu=%0b want 1 0 0 1",
               o_memwrite, o_reg_wr, o_dst, o_alu_src);
    else passed++;
    // jr $31
    instr = 32'h03E00008;
    tick();
    total++;
    if ({o_jr, o_reg_wr} !== 2'b10)
      $display("FAIL jr_bundle: got jr=%0b wr=%0b want 1 0", o_jr, o_reg_wr);
    else passed++;
    i_valid = 0;
    tick();
  endtask

  task automatic test_stall_flush();
    // ori $9,$0,0xFF
    instr = 32'h340900FF; i_valid = 1;
    tick();
    ex_ready = 0;
    instr = 32'h20010005;
    wb_we = 1; wb_addr = 5'd9; wb_data = 32'h55;
    #1;
    total++;
    if (o_ready !== 1'b0) $display("FAIL stall_ready: got %0b want 0", o_ready);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({o_valid, o_dst, o_imm, o_opcode} !== {1'b1, 5'd9, 32'hFF, 6'h0D})
        $display("FAIL stall_hold%0d: got v=%0b dst=%0d imm=%h op=%h want 1 9 ff 0d",
                 i, o_valid, o_dst, o_imm, o_opcode);
      else passed++;
    end
    wb_we = 0;
    ex_ready = 1; flush = 1;
    #1;
    total++;
    if (o_ready !== 1'b0) $display("FAIL flush_ready: got %0b want 0", o_ready);
    else passed++;
    tick();
    total++;
    if (o_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", o_valid);
    else passed++;
    flush = 0; i_valid = 0;
    tick();
    total++;
    if (o_valid !== 1'b0) $display("FAIL flush_dropped: got %0b want 0", o_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    // $3 still holds deadbeef from the bypass test
    instr = 32'h00632020; i_valid = 1;
    tick();
    total++;
    if ({o_valid, o_data_rs} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL pre_reset: got v=%0b rs=%h want 1 deadbeef", o_valid, o_data_rs);
    else passed++;
    rst_n = 0;
    tick();
    total++;
    if ({o_valid, o_data_rs, o_dst, o_reg_wr} !== 39'd0)
      $display("FAIL mid_reset: got v=%0b rs=%h dst=%0d wr=%0b want 0", o_valid, o_data_rs, o_dst, o_reg_wr);
    else passed++;
    rst_n = 1;
    #1;
    total++;
    if (o_ready !== 1'b1) $display("FAIL post_reset_ready: got %0b want 1", o_ready);
    else passed++;
    tick();
    total++;
    if ({o_valid, o_data_rs, o_data_rt, o_dst} !== {1'b1, 32'd0, 32'd0, 5'd4})
      $display("FAIL post_reset_regs: got v=%0b rs=%h rt=%h dst=%0d want 1 0 0 4",
               o_valid, o_data_rs, o_data_rt, o_dst);
    else passed++;
    i_valid = 0;
    tick();
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_zero_and_jal();
    test_stall_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
